// File: rtl/cam_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_capture : OV-series parallel pixel bus capture into addressed RGB565 writes
// Rev 1.0
// ----------------------------------------------------------------------------
module cam_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic [31:0]       debug_out
);

  localparam int                COL_W    = $clog2(H_PIXELS + 1);
  localparam logic [COL_W-1:0]  C_H_COL  = COL_W'(H_PIXELS);
  localparam logic [15:0]       C_V_LINE = 16'(V_LINES);
  localparam logic [ADDR_W-1:0] C_H_ADDR = ADDR_W'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        pclk_q, pclk_d;
  logic [2:0]        vsync_q, vsync_d;
  logic [2:0]        href_q, href_d;
  logic [7:0]        data1_q, data1_d;
  logic [7:0]        data2_q, data2_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [15:0]       line_q, line_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [7:0]        err_q, err_d;
  logic              pix_valid_q, pix_valid_d;
  logic [15:0]       pix_data_q, pix_data_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic [15:0]       lines_last_q, lines_last_d;

  logic       pe, href_fall, vrise, vfall;
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  // Index 1 is the second synchroniser stage; index 2 is the edge-detect history.
  assign pe        = pclk_q[1] & ~pclk_q[2];
  assign href_fall = href_q[2] & ~href_q[1];
  assign vrise     = vsync_q[1] & ~vsync_q[2];
  assign vfall     = ~vsync_q[1] & vsync_q[2];

  always_comb begin
    pclk_d        = {pclk_q[1:0], cam_pclk};
    vsync_d       = {vsync_q[1:0], cam_vsync};
    href_d        = {href_q[1:0], cam_href};
    data1_d       = cam_data;
    data2_d       = data1_q;
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    col_d         = col_q;
    line_d        = line_q;
    line_base_d   = line_base_q;
    err_inc       = 2'd0;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_addr_d    = pix_addr_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    lines_last_d  = lines_last_q;

    case (state_q)
      IDLE: begin
        if (cfg_done) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (vfall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (pe && href_q[1]) begin
          if (!phase_q) begin
            hi_d    = data2_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (col_q < C_H_COL && line_q < C_V_LINE) begin
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, data2_q};
              pix_addr_d  = line_base_q + ADDR_W'(col_q);
            end
            if (col_q < C_H_COL) col_d = col_q + COL_W'(1);
          end
        end

        if (href_fall) begin
          // Odd trailing byte and short line each count as one error.
          err_inc = {1'b0, phase_q} + {1'b0, (col_q < C_H_COL)};
          col_d   = '0;
          phase_d = 1'b0;
          if (line_q != 16'hFFFF) line_d = line_q + 16'd1;
          if (line_q < C_V_LINE) line_base_d = line_base_q + C_H_ADDR;
        end

        // End of frame sees the line count after any same-cycle end-of-line.
        if (vrise) begin
          lines_last_d  = line_d;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
          line_d        = '0;
          col_d         = '0;
          line_base_d   = '0;
          phase_d       = 1'b0;
          state_d       = WAIT_FRAME;
        end
      end
      default: state_d = IDLE;
    endcase

    err_sum = {1'b0, err_q} + {7'd0, err_inc};
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pclk_q        <= '0;
      vsync_q       <= '0;
      href_q        <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      col_q         <= '0;
      line_q        <= '0;
      line_base_q   <= '0;
      err_q         <= '0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_addr_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      lines_last_q  <= '0;
    end else begin
      state_q       <= state_d;
      pclk_q        <= pclk_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      col_q         <= col_d;
      line_q        <= line_d;
      line_base_q   <= line_base_d;
      err_q         <= err_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_addr_q    <= pix_addr_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      lines_last_q  <= lines_last_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_addr    = pix_addr_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign debug_out   = {frame_count_q, err_q, lines_last_q};

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cam_capture : scoreboard bench for cam_capture, reduced 4x480 frame geometry
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_cam_capture;

  localparam int H  = 4;
  localparam int V  = 480;
  localparam int AW = 11;

  typedef struct packed {
    logic [15:0]   data;
    logic [AW-1:0] addr;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_done;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [AW-1:0] pix_addr;
  logic          frame_done;
  logic [7:0]    frame_count;
  logic [31:0]   debug_out;

  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   pix_seq = 0;
  int   last_addr = -1;
  logic prev_pv = 1'b0;
  wr_t  exp_q[$];

  cam_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_done   (cfg_done),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_addr   (pix_addr),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .debug_out  (debug_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge clk) begin
    wr_t e;
    if (pix_valid) begin
      if (prev_pv) begin
        checks++;
        errors++;
        $display("FAIL pix_valid_width actual=2+ cycles required=1 cycle");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual data=%h addr=%0d required=no write", pix_data, pix_addr);
      end else begin
        e = exp_q.pop_front();
        if (pix_data !== e.data || pix_addr !== e.addr) begin
          errors++;
          $display("FAIL write actual data=%h addr=%0d required data=%h addr=%0d",
                   pix_data, pix_addr, e.data, e.addr);
        end
      end
      last_addr = int'(pix_addr);
    end
    prev_pv = pix_valid;
    if (frame_done) fd_cnt++;
  end

  task automatic pclk_cycle(input logic [7:0] b, input logic h);
    cam_data = b;
    cam_href = h;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pclk_cycle(8'h00, 1'b0);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b0;
    pix_seq   = 0;
    idle(2);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    idle(2);
  endtask

  // Pixel p of a frame carries bytes 0x12+p then 0x34+p.
  task automatic send_line(input int nbytes, input int line_no, input bit want);
    int         col;
    logic [7:0] hi, lo;
    wr_t        w;
    col = 0;
    for (int i = 0; i < nbytes; i++) begin
      hi = 8'h12 + 8'(pix_seq);
      lo = 8'h34 + 8'(pix_seq);
      if (i % 2 == 0) begin
        pclk_cycle(hi, 1'b1);
      end else begin
        if (want && col < H && line_no < V) begin
          w.data = {hi, lo};
          w.addr = AW'(line_no * H + col);
          exp_q.push_back(w);
        end
        pclk_cycle(lo, 1'b1);
        col++;
        pix_seq++;
      end
    end
    idle(1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_valid"},   32'(pix_valid),   32'd0);
    check({tag, "_pix_data"},    32'(pix_data),    32'd0);
    check({tag, "_pix_addr"},    32'(pix_addr),    32'd0);
    check({tag, "_frame_done"},  32'(frame_done),  32'd0);
    check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    check({tag, "_debug_out"},   debug_out,        32'd0);
  endtask

  initial begin
    int fd_base;
    wr_t w;
    rst = 1'b1; cfg_done = 1'b0; cam_pclk = 1'b0;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Without cfg_done the block stays idle through a whole frame.
    frame_start();
    for (int l = 0; l < 4; l++) send_line(8, l, 1'b0);
    frame_end();
    check("idle_frame_done", 32'(fd_cnt), 32'd0);
    check("idle_debug", debug_out, 32'd0);

    // Single frame, two full lines.
    cfg_done = 1'b1;
    idle(1);
    fd_base = fd_cnt;
    frame_start();
    send_line(8, 0, 1'b1);
    send_line(8, 1, 1'b1);
    frame_end();
    check("single_drained", 32'(exp_q.size()), 32'd0);
    check("single_frame_done", 32'(fd_cnt - fd_base), 32'd1);
    check("single_frame_count", 32'(frame_count), 32'd1);
    check("single_debug", debug_out, {8'd1, 8'd0, 16'd2});

    // Mid-frame start: cfg_done arrives while a line is active.
    rst = 1'b1; cfg_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fd_base = fd_cnt;
    frame_start();
    for (int i = 0; i < 3; i++) pclk_cycle(8'hA0 + 8'(i), 1'b1);
    cfg_done = 1'b1;
    for (int i = 0; i < 5; i++) pclk_cycle(8'hB0 + 8'(i), 1'b1);
    idle(1);
    frame_end();
    check("midframe_no_done", 32'(fd_cnt - fd_base), 32'd0);
    frame_start();
    send_line(8, 0, 1'b1);
    frame_end();
    check("midframe_drained", 32'(exp_q.size()), 32'd0);
    check("midframe_debug", debug_out, {8'd1, 8'd0, 16'd1});

    // Odd/short line then a full line.
    frame_start();
    send_line(7, 0, 1'b1);
    send_line(8, 1, 1'b1);
    frame_end();
    check("odd_drained", 32'(exp_q.size()), 32'd0);
    check("odd_debug", debug_out, {8'd2, 8'd2, 16'd2});

    // Over-long line: only the first H pixels are written, no error.
    frame_start();
    send_line(12, 0, 1'b1);
    frame_end();
    check("longline_drained", 32'(exp_q.size()), 32'd0);
    check("longline_debug", debug_out, {8'd3, 8'd2, 16'd1});

    // Over-tall frame: lines beyond V are counted but not written.
    frame_start();
    for (int l = 0; l < V + 2; l++) send_line(8, l, 1'b1);
    frame_end();
    check("tall_drained", 32'(exp_q.size()), 32'd0);
    check("tall_last_addr", 32'(last_addr), 32'd1919);
    check("tall_debug", debug_out, {8'd4, 8'd2, 16'd482});

    // Empty frames up to the frame_count wrap.
    fd_base = fd_cnt;
    for (int f = 0; f < 251; f++) begin
      frame_start();
      frame_end();
    end
    check("wrap_count_255", 32'(frame_count), 32'd255);
    frame_start();
    frame_end();
    check("wrap_count_0", 32'(frame_count), 32'd0);
    check("wrap_frame_dones", 32'(fd_cnt - fd_base), 32'd252);
    check("wrap_debug", debug_out, {8'd0, 8'd2, 16'd0});

    // Reset in the middle of a line.
    fd_base = fd_cnt;
    frame_start();
    w.data = 16'h1234; w.addr = AW'(0); exp_q.push_back(w);
    w.data = 16'h1335; w.addr = AW'(1); exp_q.push_back(w);
    pclk_cycle(8'h12, 1'b1);
    pclk_cycle(8'h34, 1'b1);
    pclk_cycle(8'h13, 1'b1);
    pclk_cycle(8'h35, 1'b1);
    pclk_cycle(8'h14, 1'b1);
    check("pre_reset_pix_data", 32'(pix_data), 32'h1335);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midline_reset");
    cfg_done = 1'b0;
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(3);
    check("reset_no_frame_done", 32'(fd_cnt - fd_base), 32'd0);
    check("reset_drained", 32'(exp_q.size()), 32'd0);

    // Back in IDLE: a full frame without cfg_done produces nothing.
    frame_start();
    send_line(8, 0, 1'b0);
    frame_end();
    check("reset_idle_frame_done", 32'(fd_cnt - fd_base), 32'd0);
    check("reset_idle_debug", debug_out, 32'd0);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
